// File: rtl/hazard_forward_unit.sv
// Hazard, forwarding and flush controller for a 5-stage pipeline. A shadow scoreboard
// of the EX/MEM/WB destinations drives operand selects, load-use stalls and redirects.
module hazard_forward_unit #(
   parameter int unsigned REG_ADDR_W      = 3,
   parameter int unsigned OPCODE_W        = 4,
   parameter int unsigned LOAD_USE_STALLS = 1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [OPCODE_W-1:0]   id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rd_wr,
   input  logic                  id_is_load,
   input  logic                  id_is_branch,
   input  logic                  id_branch_taken,
   input  logic                  id_is_jump,
   input  logic                  ext_stall,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  stall,
   output logic                  bubble,
   output logic                  pc_src,
   output logic                  kill,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      kill_cnt
);

   if (LOAD_USE_STALLS != 1 && LOAD_USE_STALLS != 2) begin : gBadLoadUseStalls
      $error("LOAD_USE_STALLS must be 1 or 2");
   end

   // With a single load-use bubble, load data is already usable from MEM.
   localparam logic MemLoadFwd = (LOAD_USE_STALLS == 1);

   typedef struct packed {
      logic                  v;
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
      logic                  ld;
   } shadowT;

   shadowT exQ, exD, memQ, memD, wbQ, wbD;
   logic [OPCODE_W-1:0] unusedExOpcodeQ, unusedExOpcodeD;
   logic [CNT_W-1:0]    stallCntQ, stallCntD, killCntQ, killCntD;
   logic                hz, redirect;

   function automatic logic writesReg(input shadowT s, input logic [REG_ADDR_W-1:0] r);
      return s.v && s.wr && (s.rd == r) && (r != '0);
   endfunction

   function automatic logic [1:0] fwdSel(input shadowT ex, input shadowT mem, input shadowT wb,
                                         input logic used, input logic [REG_ADDR_W-1:0] r);
      logic [1:0] sel;
      sel = 2'd0;
      if (used) begin
         if (writesReg(ex, r) && !ex.ld) begin
            sel = 2'd1;
         end else if (writesReg(mem, r) && (!mem.ld || MemLoadFwd)) begin
            sel = 2'd2;
         end else if (writesReg(wb, r)) begin
            sel = 2'd3;
         end
      end
      return sel;
   endfunction

   function automatic logic loadHaz(input shadowT ex, input shadowT mem, input logic used,
                                    input logic [REG_ADDR_W-1:0] r);
      return used && ((writesReg(ex, r) && ex.ld) ||
                      (!MemLoadFwd && writesReg(mem, r) && mem.ld));
   endfunction

   always_comb begin
      fwd_a    = fwdSel(exQ, memQ, wbQ, id_rs1_used, id_rs1);
      fwd_b    = fwdSel(exQ, memQ, wbQ, id_rs2_used, id_rs2);
      hz       = id_valid && (loadHaz(exQ, memQ, id_rs1_used, id_rs1) ||
                              loadHaz(exQ, memQ, id_rs2_used, id_rs2));
      stall    = hz | ext_stall;
      bubble   = hz & ~ext_stall;
      // A hazarded branch waits for its operands before redirecting.
      redirect = id_valid & ~stall & (id_is_jump | (id_is_branch & id_branch_taken));
      pc_src   = redirect;
      kill     = redirect;
   end

   always_comb begin
      exD             = exQ;
      memD            = memQ;
      wbD             = wbQ;
      unusedExOpcodeD = unusedExOpcodeQ;
      if (!ext_stall) begin
         wbD  = memQ;
         memD = exQ;
         if (bubble) begin
            exD             = '0;
            unusedExOpcodeD = '0;
         end else begin
            exD.v           = id_valid;
            exD.rd          = id_rd;
            exD.wr          = id_rd_wr & id_valid;
            exD.ld          = id_is_load & id_valid;
            unusedExOpcodeD = id_opcode;
         end
      end
   end

   always_comb begin
      stallCntD = stallCntQ;
      killCntD  = killCntQ;
      if (stall && (stallCntQ != '1)) begin
         stallCntD = stallCntQ + 1'b1;
      end
      if (kill && (killCntQ != '1)) begin
         killCntD = killCntQ + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exQ             <= '0;
         memQ            <= '0;
         wbQ             <= '0;
         unusedExOpcodeQ <= '0;
         stallCntQ       <= '0;
         killCntQ        <= '0;
      end else begin
         exQ             <= exD;
         memQ            <= memD;
         wbQ             <= wbD;
         unusedExOpcodeQ <= unusedExOpcodeD;
         stallCntQ       <= stallCntD;
         killCntQ        <= killCntD;
      end
   end

   assign stall_cnt = stallCntQ;
   assign kill_cnt  = killCntQ;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a vector table on a LOAD_USE_STALLS=1 instance
// plus hand sequences for freeze, async reset, LOAD_USE_STALLS=2 and counter saturation.
module tb_hazard_forward_unit;

   logic       clk, rst_n;
   logic       id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_is_load;
   logic       id_is_branch, id_branch_taken, id_is_jump, ext_stall;
   logic [3:0] id_opcode;
   logic [2:0] id_rs1, id_rs2, id_rd;

   logic [1:0]  fwdA1, fwdB1, fwdA2, fwdB2;
   logic        stall1, bubble1, pcSrc1, kill1, stall2, bubble2, pcSrc2, kill2;
   logic [3:0]  stallCnt1, killCnt1;
   logic [15:0] stallCnt2, killCnt2;

   int total = 0;
   int bad   = 0;

   hazard_forward_unit #(.REG_ADDR_W(3), .OPCODE_W(4), .LOAD_USE_STALLS(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
      .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
      .id_is_jump(id_is_jump), .ext_stall(ext_stall), .fwd_a(fwdA1), .fwd_b(fwdB1),
      .stall(stall1), .bubble(bubble1), .pc_src(pcSrc1), .kill(kill1),
      .stall_cnt(stallCnt1), .kill_cnt(killCnt1)
   );

   hazard_forward_unit #(.REG_ADDR_W(3), .OPCODE_W(4), .LOAD_USE_STALLS(2), .CNT_W(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
      .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
      .id_is_jump(id_is_jump), .ext_stall(ext_stall), .fwd_a(fwdA2), .fwd_b(fwdB2),
      .stall(stall2), .bubble(bubble2), .pc_src(pcSrc2), .kill(kill2),
      .stall_cnt(stallCnt2), .kill_cnt(killCnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int v, rs1, u1, rs2, u2, rd, wr, ld, br, tk, jp, ext;
      int eA, eB, eS, eBub, eK, eSC, eKC;
   } vecT;

   vecT vecs[22];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic setIn(input vecT t, input int op);
      id_valid        = t.v[0];
      id_rs1          = t.rs1[2:0];
      id_rs1_used     = t.u1[0];
      id_rs2          = t.rs2[2:0];
      id_rs2_used     = t.u2[0];
      id_rd           = t.rd[2:0];
      id_rd_wr        = t.wr[0];
      id_is_load      = t.ld[0];
      id_is_branch    = t.br[0];
      id_branch_taken = t.tk[0];
      id_is_jump      = t.jp[0];
      ext_stall       = t.ext[0];
      id_opcode       = op[3:0];
   endtask

   task automatic idle();
      vecT z;
      z = '{default: 0};
      setIn(z, 0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rstPulse();
      idle();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   // Shorthand for one ID instruction in the hand-written sequences.
   function automatic vecT ins(input int v, input int rs1, input int u1, input int rd,
                               input int wr, input int ld, input int br, input int tk,
                               input int ext);
      vecT t;
      t = '{default: 0};
      t.v = v; t.rs1 = rs1; t.u1 = u1; t.rd = rd; t.wr = wr; t.ld = ld;
      t.br = br; t.tk = tk; t.ext = ext;
      return t;
   endfunction

   initial begin
      //          v rs1 u1 rs2 u2 rd wr ld br tk jp ext  eA eB eS eBub eK eSC eKC
      vecs[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0, 0, 0};
      vecs[5]  = '{1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
      vecs[6]  = '{1, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0};
      vecs[7]  = '{1, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1, 0};
      vecs[8]  = '{1, 0, 1, 5, 1, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0};
      vecs[9]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
      vecs[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
      vecs[11] = '{1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
      vecs[12] = '{1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0};
      vecs[13] = '{1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1, 0};
      vecs[14] = '{1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 0, 1, 0};
      vecs[15] = '{1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
      vecs[16] = '{1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 1, 0, 1, 0};
      vecs[17] = '{1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,  2, 0, 0, 0, 1, 2, 0};
      vecs[18] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 2, 1};
      vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 2, 2};
      vecs[20] = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0, 0, 2, 2};
      vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3, 2};

      rst_n = 1'b0;
      idle();
      #3;
      chk("reset stall_cnt", int'(stallCnt1), 0);
      chk("reset kill_cnt", int'(killCnt1), 0);
      chk("reset fwd_a", int'(fwdA1), 0);
      chk("reset stall", int'(stall1), 0);
      chk("reset kill", int'(kill2), 0);
      nextCycle();
      rst_n = 1'b1;

      // Table on the single-bubble instance.
      for (int i = 0; i < 22; i++) begin
         setIn(vecs[i], i);
         @(negedge clk);
         chk($sformatf("row%0d fwd_a", i), int'(fwdA1), vecs[i].eA);
         chk($sformatf("row%0d fwd_b", i), int'(fwdB1), vecs[i].eB);
         chk($sformatf("row%0d stall", i), int'(stall1), vecs[i].eS);
         chk($sformatf("row%0d bubble", i), int'(bubble1), vecs[i].eBub);
         chk($sformatf("row%0d kill", i), int'(kill1), vecs[i].eK);
         chk($sformatf("row%0d pc_src", i), int'(pcSrc1), vecs[i].eK);
         chk($sformatf("row%0d stall_cnt", i), int'(stallCnt1), vecs[i].eSC);
         chk($sformatf("row%0d kill_cnt", i), int'(killCnt1), vecs[i].eKC);
         nextCycle();
      end

      // Freeze: ADD R1, then a taken branch on R1 held by ext_stall for 3 cycles.
      rstPulse();
      setIn(ins(1, 0, 0, 1, 1, 0, 0, 0, 0), 1);
      nextCycle();
      for (int k = 0; k < 3; k++) begin
         setIn(ins(1, 1, 1, 0, 0, 0, 1, 1, 1), 2);
         @(negedge clk);
         chk($sformatf("frz%0d fwd_a", k), int'(fwdA1), 1);
         chk($sformatf("frz%0d stall", k), int'(stall1), 1);
         chk($sformatf("frz%0d bubble", k), int'(bubble1), 0);
         chk($sformatf("frz%0d kill", k), int'(kill1), 0);
         nextCycle();
      end
      setIn(ins(1, 1, 1, 0, 0, 0, 1, 1, 0), 2);
      @(negedge clk);
      chk("thaw fwd_a", int'(fwdA1), 1);
      chk("thaw stall", int'(stall1), 0);
      chk("thaw kill", int'(kill1), 1);
      chk("thaw stall_cnt", int'(stallCnt1), 3);
      chk("thaw kill_cnt", int'(killCnt1), 0);
      nextCycle();
      setIn(ins(1, 1, 1, 0, 0, 0, 0, 0, 0), 3);
      @(negedge clk);
      chk("post-thaw fwd_a", int'(fwdA1), 2);
      chk("post-thaw kill_cnt", int'(killCnt1), 1);

      // Asynchronous reset in the middle of a cycle.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst stall_cnt", int'(stallCnt1), 0);
      chk("async rst kill_cnt", int'(killCnt1), 0);
      chk("async rst fwd_a", int'(fwdA1), 0);
      #1;
      rst_n = 1'b1;
      nextCycle();

      // Two-bubble instance: LW R2 then a consumer of R2.
      rstPulse();
      setIn(ins(1, 0, 0, 2, 1, 1, 0, 0, 0), 4);
      @(negedge clk);
      chk("lus2 load stall", int'(stall2), 0);
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         setIn(ins(1, 2, 1, 5, 1, 0, 0, 0, 0), 5);
         @(negedge clk);
         chk($sformatf("lus2 stall%0d", k), int'(stall2), 1);
         chk($sformatf("lus2 bubble%0d", k), int'(bubble2), 1);
         chk($sformatf("lus2 fwd_a%0d", k), int'(fwdA2), 0);
         nextCycle();
      end
      setIn(ins(1, 2, 1, 5, 1, 0, 0, 0, 0), 5);
      @(negedge clk);
      chk("lus2 release stall", int'(stall2), 0);
      chk("lus2 release fwd_a", int'(fwdA2), 3);
      chk("lus2 stall_cnt", int'(stallCnt2), 2);
      nextCycle();

      // Saturation of the 4-bit stall counter under a long ext_stall.
      rstPulse();
      ext_stall = 1'b1;
      repeat (14) @(posedge clk);
      @(negedge clk);
      chk("sat stall_cnt at 14", int'(stallCnt1), 14);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sat stall_cnt held", int'(stallCnt1), 15);
      chk("wide stall_cnt 20", int'(stallCnt2), 20);
      ext_stall = 1'b0;
      nextCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
